// File: rtl/id_ex_pkg.sv
// Shared types and constants for the ID/EX pipeline stage.
// Build option: define ID_EX_FORWARD_EN to enable EX/MEM forwarding (load-use stalls only).
package id_ex_pkg;

  localparam int DATA_WIDTH_DEF     = 32;
  localparam int REG_ADDR_WIDTH_DEF = 5;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;
  localparam logic [3:0] ALU_LUI  = 4'b1010;
  localparam logic [3:0] ALU_JALR = 4'b1011;
  localparam logic [3:0] ALU_BNE  = 4'b1100;
  localparam logic [3:0] ALU_BEQ  = 4'b1101;

  typedef enum logic {
    ST_RUN,
    ST_STALL
  } stall_state_e;

  // Without EX/MEM forwarding a producer must reach WB before its consumer enters EX.
`ifdef ID_EX_FORWARD_EN
  localparam bit         EXM_FWD   = 1'b1;
  localparam logic [1:0] STALL_LEN = 2'd1;
`else
  localparam bit         EXM_FWD   = 1'b0;
  localparam logic [1:0] STALL_LEN = 2'd2;
`endif

endpackage

// File: rtl/id_ex_if.sv
// Decode-to-execute bus: decode fields, writeback sources and the EX-side drive.
import id_ex_pkg::*;

interface id_ex_if #(
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF
);
  logic                      id_valid;
  logic                      id_ready;
  logic [REG_ADDR_WIDTH-1:0] id_rs1;
  logic [REG_ADDR_WIDTH-1:0] id_rs2;
  logic [REG_ADDR_WIDTH-1:0] id_rd;
  logic                      id_rs1_used;
  logic                      id_rs2_used;
  logic [DATA_WIDTH-1:0]     id_rd1;
  logic [DATA_WIDTH-1:0]     id_rd2;
  logic [DATA_WIDTH-1:0]     id_imm;
  logic [DATA_WIDTH-1:0]     id_pc;
  logic                      id_alu_src;
  logic [3:0]                id_alu_ctrl;
  logic                      id_reg_write;
  logic                      id_mem_read;
  logic                      id_mem_write;
  logic                      flush;
  logic [REG_ADDR_WIDTH-1:0] exm_rd;
  logic                      exm_reg_write;
  logic [DATA_WIDTH-1:0]     exm_result;
  logic [REG_ADDR_WIDTH-1:0] wb_rd;
  logic                      wb_reg_write;
  logic [DATA_WIDTH-1:0]     wb_result;
  logic                      ex_valid;
  logic [DATA_WIDTH-1:0]     SrcA;
  logic [DATA_WIDTH-1:0]     SrcB;
  logic [3:0]                ALUControl;
  logic [REG_ADDR_WIDTH-1:0] ex_rd;
  logic                      ex_reg_write;
  logic                      ex_mem_read;
  logic                      ex_mem_write;
  logic [DATA_WIDTH-1:0]     ex_store_data;
  logic [DATA_WIDTH-1:0]     ex_pc;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rd, id_rs1_used, id_rs2_used,
           id_rd1, id_rd2, id_imm, id_pc, id_alu_src, id_alu_ctrl,
           id_reg_write, id_mem_read, id_mem_write, flush,
           exm_rd, exm_reg_write, exm_result, wb_rd, wb_reg_write, wb_result,
    input  id_ready, ex_valid, SrcA, SrcB, ALUControl, ex_rd, ex_reg_write,
           ex_mem_read, ex_mem_write, ex_store_data, ex_pc
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rd, id_rs1_used, id_rs2_used,
           id_rd1, id_rd2, id_imm, id_pc, id_alu_src, id_alu_ctrl,
           id_reg_write, id_mem_read, id_mem_write, flush,
           exm_rd, exm_reg_write, exm_result, wb_rd, wb_reg_write, wb_result,
    output id_ready, ex_valid, SrcA, SrcB, ALUControl, ex_rd, ex_reg_write,
           ex_mem_read, ex_mem_write, ex_store_data, ex_pc
  );
endinterface

// File: rtl/fwd_unit.sv
// Operand bypass for one source register: EX/MEM result, then WB result, else regfile data.
import id_ex_pkg::*;

module fwd_unit #(
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF,
  parameter bit EXM_EN         = 1'b1
) (
  input  logic [REG_ADDR_WIDTH-1:0] rs_i,
  input  logic [DATA_WIDTH-1:0]     reg_data_i,
  input  logic [REG_ADDR_WIDTH-1:0] exm_rd_i,
  input  logic                      exm_reg_write_i,
  input  logic [DATA_WIDTH-1:0]     exm_result_i,
  input  logic [REG_ADDR_WIDTH-1:0] wb_rd_i,
  input  logic                      wb_reg_write_i,
  input  logic [DATA_WIDTH-1:0]     wb_result_i,
  output logic [DATA_WIDTH-1:0]     data_o
);

  logic exm_hit;
  logic wb_hit;

  // x0 is hardwired to zero, so a write to it must never be bypassed.
  always_comb begin
    exm_hit = EXM_EN && exm_reg_write_i && (exm_rd_i != '0) && (exm_rd_i == rs_i);
    wb_hit  = wb_reg_write_i && (wb_rd_i != '0) && (wb_rd_i == rs_i);
    if (exm_hit)     data_o = exm_result_i;
    else if (wb_hit) data_o = wb_result_i;
    else             data_o = reg_data_i;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and hazard stall control.
// Build option: ID_EX_FORWARD_EN (EX/MEM forwarding, 1-cycle load-use stall); default stalls 2 cycles on any RAW.
import id_ex_pkg::*;

module id_ex_stage #(
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF
) (
  input logic   clk,
  input logic   rst,
  id_ex_if.slave bus
);

  stall_state_e              state_q;
  logic [1:0]                cnt_q;
  logic                      valid_q;
  logic [REG_ADDR_WIDTH-1:0] rs1_q;
  logic [REG_ADDR_WIDTH-1:0] rs2_q;
  logic [REG_ADDR_WIDTH-1:0] rd_q;
  logic [DATA_WIDTH-1:0]     rd1_q;
  logic [DATA_WIDTH-1:0]     rd2_q;
  logic [DATA_WIDTH-1:0]     imm_q;
  logic [DATA_WIDTH-1:0]     pc_q;
  logic                      alu_src_q;
  logic [3:0]                alu_ctrl_q;
  logic                      reg_write_q;
  logic                      mem_read_q;
  logic                      mem_write_q;

  logic                      hazard;
  logic                      ready;
  logic                      producer;
  logic [DATA_WIDTH-1:0]     fwd_a;
  logic [DATA_WIDTH-1:0]     fwd_b;

  // With EX/MEM forwarding only a load is too late; otherwise any writer in EX is.
  always_comb begin
    producer = EXM_FWD ? mem_read_q : reg_write_q;
    hazard   = bus.id_valid && valid_q && producer && (rd_q != '0) &&
               ((bus.id_rs1_used && (bus.id_rs1 == rd_q)) ||
                (bus.id_rs2_used && (bus.id_rs2 == rd_q)));
    ready    = !(((state_q == ST_STALL) && (cnt_q != 2'd0)) || hazard);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      cnt_q   <= 2'd0;
    end else if (bus.flush) begin
      state_q <= ST_RUN;
      cnt_q   <= 2'd0;
    end else if ((state_q == ST_STALL) && (cnt_q != 2'd0)) begin
      cnt_q <= cnt_q - 2'd1;
    end else if (hazard) begin
      state_q <= ST_STALL;
      cnt_q   <= STALL_LEN - 2'd1;
    end else begin
      state_q <= ST_RUN;
    end
  end

  // Control bits are qualified by valid so a bubble can never write state downstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= 1'b0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      rd1_q       <= '0;
      rd2_q       <= '0;
      imm_q       <= '0;
      pc_q        <= '0;
      alu_src_q   <= 1'b0;
      alu_ctrl_q  <= 4'b0000;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else if (bus.flush || !ready) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else begin
      valid_q     <= bus.id_valid;
      rs1_q       <= bus.id_rs1;
      rs2_q       <= bus.id_rs2;
      rd_q        <= bus.id_rd;
      rd1_q       <= bus.id_rd1;
      rd2_q       <= bus.id_rd2;
      imm_q       <= bus.id_imm;
      pc_q        <= bus.id_pc;
      alu_src_q   <= bus.id_alu_src;
      alu_ctrl_q  <= bus.id_alu_ctrl;
      reg_write_q <= bus.id_reg_write & bus.id_valid;
      mem_read_q  <= bus.id_mem_read & bus.id_valid;
      mem_write_q <= bus.id_mem_write & bus.id_valid;
    end
  end

  fwd_unit #(
    .DATA_WIDTH(DATA_WIDTH), .REG_ADDR_WIDTH(REG_ADDR_WIDTH), .EXM_EN(EXM_FWD)
  ) u_fwd_a (
    .rs_i(rs1_q), .reg_data_i(rd1_q),
    .exm_rd_i(bus.exm_rd), .exm_reg_write_i(bus.exm_reg_write), .exm_result_i(bus.exm_result),
    .wb_rd_i(bus.wb_rd), .wb_reg_write_i(bus.wb_reg_write), .wb_result_i(bus.wb_result),
    .data_o(fwd_a)
  );

  fwd_unit #(
    .DATA_WIDTH(DATA_WIDTH), .REG_ADDR_WIDTH(REG_ADDR_WIDTH), .EXM_EN(EXM_FWD)
  ) u_fwd_b (
    .rs_i(rs2_q), .reg_data_i(rd2_q),
    .exm_rd_i(bus.exm_rd), .exm_reg_write_i(bus.exm_reg_write), .exm_result_i(bus.exm_result),
    .wb_rd_i(bus.wb_rd), .wb_reg_write_i(bus.wb_reg_write), .wb_result_i(bus.wb_result),
    .data_o(fwd_b)
  );

  assign bus.id_ready      = ready;
  assign bus.ex_valid      = valid_q;
  assign bus.SrcA          = fwd_a;
  assign bus.SrcB          = alu_src_q ? imm_q : fwd_b;
  assign bus.ex_store_data = fwd_b;
  assign bus.ALUControl    = alu_ctrl_q;
  assign bus.ex_rd         = rd_q;
  assign bus.ex_reg_write  = reg_write_q;
  assign bus.ex_mem_read   = mem_read_q;
  assign bus.ex_mem_write  = mem_write_q;
  assign bus.ex_pc         = pc_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed pipeline scenarios plus randomized traffic against a reference model.
// Honors ID_EX_FORWARD_EN the same way as the design build.
module tb_id_ex_stage;
  import id_ex_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;
`ifdef ID_EX_FORWARD_EN
  localparam bit FWD      = 1'b1;
  localparam int LOAD_STL = 1;
  localparam int ALU_STL  = 0;
`else
  localparam bit FWD      = 1'b0;
  localparam int LOAD_STL = 2;
  localparam int ALU_STL  = 2;
`endif

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] rs1, rs2, rd;
    logic [DW-1:0] rd1, rd2, imm, pc;
    logic          alu_src;
    logic [3:0]    ctrl;
    logic          rw, mr, mw;
  } exModel_t;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  id_ex_if #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW)) bus ();

  id_ex_stage #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic clearAll();
    bus.id_valid = 0; bus.id_rs1 = '0; bus.id_rs2 = '0; bus.id_rd = '0;
    bus.id_rs1_used = 0; bus.id_rs2_used = 0;
    bus.id_rd1 = '0; bus.id_rd2 = '0; bus.id_imm = '0; bus.id_pc = '0;
    bus.id_alu_src = 0; bus.id_alu_ctrl = ALU_ADD;
    bus.id_reg_write = 0; bus.id_mem_read = 0; bus.id_mem_write = 0;
    bus.flush = 0;
    bus.exm_rd = '0; bus.exm_reg_write = 0; bus.exm_result = '0;
    bus.wb_rd = '0; bus.wb_reg_write = 0; bus.wb_result = '0;
  endtask

  task automatic driveInstr(input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                            input logic [AW-1:0] rd, input logic u1, input logic u2,
                            input logic [DW-1:0] rd1, input logic [DW-1:0] rd2,
                            input logic [DW-1:0] imm, input logic asrc,
                            input logic [3:0] ctrl, input logic rw, input logic mr);
    bus.id_valid = 1; bus.id_rs1 = rs1; bus.id_rs2 = rs2; bus.id_rd = rd;
    bus.id_rs1_used = u1; bus.id_rs2_used = u2;
    bus.id_rd1 = rd1; bus.id_rd2 = rd2; bus.id_imm = imm; bus.id_pc = 32'h100;
    bus.id_alu_src = asrc; bus.id_alu_ctrl = ctrl;
    bus.id_reg_write = rw; bus.id_mem_read = mr; bus.id_mem_write = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    clearAll();
    tick();
  endtask

  task automatic test_reset();
    rst = 1;
    clearAll();
    tick();
    rst = 0;
    checks++; if (bus.ex_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_ex_valid got %b want 0", bus.ex_valid); end
    checks++; if ({bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write} !== 3'b000) begin errors++; $display("[TB] FAIL reset_ctrl got %b want 000", {bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write}); end
    checks++; if (bus.ALUControl !== 4'h0) begin errors++; $display("[TB] FAIL reset_aluctrl got %h want 0", bus.ALUControl); end
    checks++; if (bus.SrcA !== 32'h0 || bus.ex_pc !== 32'h0 || bus.ex_rd !== 5'h0) begin errors++; $display("[TB] FAIL reset_data SrcA=%h pc=%h rd=%0d want all 0", bus.SrcA, bus.ex_pc, bus.ex_rd); end
    checks++; if (bus.id_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_id_ready got %b want 1", bus.id_ready); end
  endtask

  // add x5,x1,x2 then add x6,x5,x3 (x0 as rs2 when stalling without forwarding)
  task automatic test_alu_forward();
    driveInstr(5'd1, 5'd2, 5'd5, 1, 1, 32'h11, 32'h22, 32'h0, 0, ALU_ADD, 1, 0);
    tick();
    driveInstr(5'd5, FWD ? 5'd3 : 5'd0, 5'd6, 1, 1, 32'hDEAD, 32'h33, 32'h0, 0, ALU_ADD, 1, 0);
    for (int i = 0; i < ALU_STL; i++) begin
      @(negedge clk);
      checks++; if (bus.id_ready !== 1'b0) begin errors++; $display("[TB] FAIL alu_stall_ready cyc %0d got %b want 0", i, bus.id_ready); end
      tick();
      checks++; if (bus.ex_valid !== 1'b0) begin errors++; $display("[TB] FAIL alu_bubble cyc %0d got %b want 0", i, bus.ex_valid); end
    end
    @(negedge clk);
    checks++; if (bus.id_ready !== 1'b1) begin errors++; $display("[TB] FAIL alu_ready got %b want 1", bus.id_ready); end
    tick();
    bus.id_valid = 0;
    bus.exm_rd = 5'd5; bus.exm_reg_write = 1; bus.exm_result = 32'h10;
    bus.wb_rd = 5'd5; bus.wb_reg_write = 1; bus.wb_result = 32'h5A;
    #1;
    checks++; if (bus.SrcA !== (FWD ? 32'h10 : 32'h5A)) begin errors++; $display("[TB] FAIL alu_fwd_srca got %h want %h", bus.SrcA, FWD ? 32'h10 : 32'h5A); end
    checks++; if (bus.ex_valid !== 1'b1 || bus.ex_rd !== 5'd6) begin errors++; $display("[TB] FAIL alu_consumer valid=%b rd=%0d want 1/6", bus.ex_valid, bus.ex_rd); end
    idle();
  endtask

  // lw x5 then add x6,x5,x5
  task automatic test_load_use();
    driveInstr(5'd1, 5'd0, 5'd5, 1, 0, 32'h40, 32'h0, 32'h4, 1, ALU_ADD, 1, 1);
    tick();
    driveInstr(5'd5, 5'd5, 5'd6, 1, 1, 32'hDEAD, 32'hBEEF, 32'h0, 0, ALU_ADD, 1, 0);
    for (int i = 0; i < LOAD_STL; i++) begin
      @(negedge clk);
      checks++; if (bus.id_ready !== 1'b0) begin errors++; $display("[TB] FAIL lu_stall_ready cyc %0d got %b want 0", i, bus.id_ready); end
      tick();
      checks++; if (bus.ex_valid !== 1'b0 || bus.ex_reg_write !== 1'b0) begin errors++; $display("[TB] FAIL lu_bubble cyc %0d valid=%b rw=%b want 0/0", i, bus.ex_valid, bus.ex_reg_write); end
    end
    @(negedge clk);
    checks++; if (bus.id_ready !== 1'b1) begin errors++; $display("[TB] FAIL lu_ready got %b want 1", bus.id_ready); end
    tick();
    bus.id_valid = 0;
    bus.wb_rd = 5'd5; bus.wb_reg_write = 1; bus.wb_result = 32'hAB;
    #1;
    checks++; if (bus.SrcA !== 32'hAB || bus.SrcB !== 32'hAB) begin errors++; $display("[TB] FAIL lu_operands SrcA=%h SrcB=%h want AB/AB", bus.SrcA, bus.SrcB); end
    checks++; if (bus.ex_store_data !== 32'hAB || bus.ex_valid !== 1'b1) begin errors++; $display("[TB] FAIL lu_store got %h valid %b want AB/1", bus.ex_store_data, bus.ex_valid); end
    idle();
  endtask

  task automatic test_priority();
    driveInstr(5'd7, 5'd0, 5'd9, 1, 0, 32'h99, 32'h0, 32'h0, 0, ALU_OR, 1, 0);
    tick();
    bus.exm_rd = 5'd7; bus.exm_reg_write = 1; bus.exm_result = 32'h1;
    bus.wb_rd = 5'd7; bus.wb_reg_write = 1; bus.wb_result = 32'h2;
    #1;
    checks++; if (bus.SrcA !== (FWD ? 32'h1 : 32'h2)) begin errors++; $display("[TB] FAIL prio_x7 got %h want %h", bus.SrcA, FWD ? 32'h1 : 32'h2); end
    driveInstr(5'd0, 5'd0, 5'd10, 1, 0, 32'h77, 32'h0, 32'h0, 0, ALU_OR, 1, 0);
    bus.exm_rd = 5'd0; bus.wb_rd = 5'd0;
    tick();
    checks++; if (bus.SrcA !== 32'h77) begin errors++; $display("[TB] FAIL prio_x0 got %h want 77", bus.SrcA); end
    idle();
  endtask

  task automatic test_flush();
    driveInstr(5'd1, 5'd0, 5'd5, 1, 0, 32'h0, 32'h0, 32'h8, 1, ALU_ADD, 1, 1);
    tick();
    driveInstr(5'd5, 5'd0, 5'd6, 1, 0, 32'h0, 32'h0, 32'h0, 0, ALU_SUB, 1, 0);
    bus.flush = 1;
    @(negedge clk);
    checks++; if (bus.id_ready !== 1'b0) begin errors++; $display("[TB] FAIL flush_hazard_ready got %b want 0", bus.id_ready); end
    tick();
    bus.flush = 0;
    #1;
    checks++; if (bus.ex_valid !== 1'b0 || bus.ex_reg_write !== 1'b0 || bus.ex_mem_read !== 1'b0) begin errors++; $display("[TB] FAIL flush_ex valid=%b rw=%b mr=%b want 000", bus.ex_valid, bus.ex_reg_write, bus.ex_mem_read); end
    checks++; if (bus.id_ready !== 1'b1) begin errors++; $display("[TB] FAIL flush_ready got %b want 1", bus.id_ready); end
    idle();
  endtask

  task automatic test_reset_mid_stall();
    driveInstr(5'd1, 5'd0, 5'd5, 1, 0, 32'h0, 32'h0, 32'h8, 1, ALU_SLL, 1, 1);
    tick();
    driveInstr(5'd5, 5'd0, 5'd6, 1, 0, 32'h0, 32'h0, 32'h0, 0, ALU_SUB, 1, 0);
    @(negedge clk);
    checks++; if (bus.id_ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_stall_ready got %b want 0", bus.id_ready); end
    tick();
    rst = 1;
    tick();
    rst = 0;
    checks++; if (bus.ex_valid !== 1'b0 || bus.ALUControl !== 4'h0) begin errors++; $display("[TB] FAIL rst_stall_ex valid=%b alu=%h want 0/0", bus.ex_valid, bus.ALUControl); end
    checks++; if (bus.id_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_stall_ready_after got %b want 1", bus.id_ready); end
    idle();
  endtask

  function automatic logic [DW-1:0] fwdRef(input logic [AW-1:0] rs, input logic [DW-1:0] regv);
    if (rs == 0) return regv;
    if (FWD && bus.exm_reg_write && bus.exm_rd == rs) return bus.exm_result;
    if (bus.wb_reg_write && bus.wb_rd == rs) return bus.wb_result;
    return regv;
  endfunction

  // Model: a RAW against the EX occupant holds decode for a fixed number of cycles, each inserting a bubble.
  task automatic test_random();
    exModel_t m = '0;
    int stallLeft = 0;
    int nextStall;
    logic expReady, hz, prod;
    logic [DW-1:0] expB;
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      bus.flush = ($urandom_range(0, 19) == 0);
      bus.id_valid = ($urandom_range(0, 9) != 0);
      bus.id_rs1 = AW'($urandom_range(0, 7)); bus.id_rs2 = AW'($urandom_range(0, 7));
      bus.id_rd = AW'($urandom_range(0, 7));
      bus.id_rs1_used = ($urandom_range(0, 3) != 0); bus.id_rs2_used = ($urandom_range(0, 1) != 0);
      bus.id_rd1 = $urandom; bus.id_rd2 = $urandom; bus.id_imm = $urandom; bus.id_pc = $urandom;
      bus.id_alu_src = ($urandom_range(0, 1) != 0); bus.id_alu_ctrl = 4'($urandom_range(0, 13));
      bus.id_reg_write = ($urandom_range(0, 3) != 0); bus.id_mem_read = ($urandom_range(0, 2) == 0);
      bus.id_mem_write = ($urandom_range(0, 4) == 0);
      bus.exm_rd = AW'($urandom_range(0, 7)); bus.exm_reg_write = ($urandom_range(0, 1) != 0); bus.exm_result = $urandom;
      bus.wb_rd = AW'($urandom_range(0, 7)); bus.wb_reg_write = ($urandom_range(0, 1) != 0); bus.wb_result = $urandom;
      @(negedge clk);
      prod = FWD ? m.mr : m.rw;
      hz = bus.id_valid && m.valid && prod && (m.rd != 0) &&
           ((bus.id_rs1_used && bus.id_rs1 == m.rd) || (bus.id_rs2_used && bus.id_rs2 == m.rd));
      if (stallLeft > 0) begin expReady = 0; nextStall = stallLeft - 1; end
      else if (hz) begin expReady = 0; nextStall = (FWD ? 1 : 2) - 1; end
      else begin expReady = 1; nextStall = 0; end
      checks++; if (bus.id_ready !== expReady) begin errors++; $display("[TB] FAIL rand_ready cyc %0d got %b want %b", c, bus.id_ready, expReady); end
      checks++; if ({bus.ex_valid, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write} !== {m.valid, m.rw, m.mr, m.mw}) begin errors++; $display("[TB] FAIL rand_ctrl cyc %0d got %b want %b", c, {bus.ex_valid, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write}, {m.valid, m.rw, m.mr, m.mw}); end
      if (m.valid) begin
        expB = m.alu_src ? m.imm : fwdRef(m.rs2, m.rd2);
        checks++; if (bus.SrcA !== fwdRef(m.rs1, m.rd1)) begin errors++; $display("[TB] FAIL rand_srca cyc %0d got %h want %h", c, bus.SrcA, fwdRef(m.rs1, m.rd1)); end
        checks++; if (bus.SrcB !== expB) begin errors++; $display("[TB] FAIL rand_srcb cyc %0d got %h want %h", c, bus.SrcB, expB); end
        checks++; if (bus.ex_store_data !== fwdRef(m.rs2, m.rd2)) begin errors++; $display("[TB] FAIL rand_store cyc %0d got %h want %h", c, bus.ex_store_data, fwdRef(m.rs2, m.rd2)); end
        checks++; if ({bus.ALUControl, bus.ex_rd, bus.ex_pc} !== {m.ctrl, m.rd, m.pc}) begin errors++; $display("[TB] FAIL rand_fields cyc %0d got %h/%0d/%h want %h/%0d/%h", c, bus.ALUControl, bus.ex_rd, bus.ex_pc, m.ctrl, m.rd, m.pc); end
      end
      @(posedge clk);
      if (rst) begin
        m = '0; stallLeft = 0;
      end else if (bus.flush) begin
        m.valid = 0; m.rw = 0; m.mr = 0; m.mw = 0; stallLeft = 0;
      end else begin
        stallLeft = nextStall;
        if (expReady) begin
          m.valid = bus.id_valid; m.rs1 = bus.id_rs1; m.rs2 = bus.id_rs2; m.rd = bus.id_rd;
          m.rd1 = bus.id_rd1; m.rd2 = bus.id_rd2; m.imm = bus.id_imm; m.pc = bus.id_pc;
          m.alu_src = bus.id_alu_src; m.ctrl = bus.id_alu_ctrl;
          m.rw = bus.id_reg_write & bus.id_valid; m.mr = bus.id_mem_read & bus.id_valid;
          m.mw = bus.id_mem_write & bus.id_valid;
        end else begin
          m.valid = 0; m.rw = 0; m.mr = 0; m.mw = 0;
        end
      end
      #1;
    end
    rst = 0;
    idle();
  endtask

  initial begin
    $display("[TB] id_ex_stage bench, EX/MEM forwarding=%0d", FWD);
    test_reset();
    test_alu_forward();
    test_load_use();
    test_priority();
    test_flush();
    test_reset_mid_stall();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter DATA_WIDTH, default 32, operand/result width.
REQ-002 Parameter REG_ADDR_WIDTH, default 5, register index width.
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 id_valid  in  1  decode holds a valid instruction.
REQ-006 id_ready  out  1  stage accepts decode this cycle (0 = stall decode/fetch).
REQ-007 id_rs1, id_rs2, id_rd  in  REG_ADDR_WIDTH  source/destination indices.
REQ-008 id_rs1_used, id_rs2_used  in  1  instruction actually reads rs1/rs2.
REQ-009 id_rd1, id_rd2, id_imm, id_pc  in  DATA_WIDTH  regfile data, immediate, PC.
REQ-010 id_alu_src  in  1  1 = SrcB from immediate; id_alu_ctrl  in  4  ALU opcode.
REQ-011 id_reg_write, id_mem_read, id_mem_write  in  1  decoded control bits.
REQ-012 flush  in  1  taken branch/jump: kill the instruction entering EX.
REQ-013 exm_rd  in  REG_ADDR_WIDTH; exm_reg_write  in  1; exm_result  in  DATA_WIDTH  EX/MEM writeback source.
REQ-014 wb_rd  in  REG_ADDR_WIDTH; wb_reg_write  in  1; wb_result  in  DATA_WIDTH  WB writeback source.
REQ-015 ex_valid  out  1; SrcA, SrcB  out  DATA_WIDTH; ALUControl  out  4  ALU drive.
REQ-016 ex_rd  out  REG_ADDR_WIDTH; ex_reg_write, ex_mem_read, ex_mem_write  out  1; ex_store_data, ex_pc  out  DATA_WIDTH.

Function
REQ-017 Capture: on clk when id_ready=1, EX register loads all id_* fields; ex_valid <= id_valid & ~flush.
REQ-018 Bubble: on clk when id_ready=0, ex_valid<=0 and ex_reg_write/ex_mem_read/ex_mem_write<=0; decode side holds its instruction.
REQ-019 Flush has priority over stall and capture: next cycle ex_valid=0, all EX control bits 0, FSM to RUN.
REQ-020 Operand select (combinational from EX register): forwarded rs1 value -> SrcA; SrcB = imm if alu_src else forwarded rs2; ex_store_data = forwarded rs2.
REQ-021 Forward match: source reg_write=1, source rd!=0, rd == EX rs; EX/MEM beats WB; no match -> registered regfile data; x0 never forwarded.
REQ-022 WB bypass always active (write-through equivalent), independent of configuration.
REQ-023 Hazard: EX slot valid, ex_mem_read=1, ex_rd!=0, ex_rd equals id_rs1 (id_rs1_used) or id_rs2 (id_rs2_used), id_valid=1.
REQ-024 FSM states RUN, STALL; RUN->STALL on hazard (id_ready=0 that cycle); STALL->RUN after stall counter expires; id_ready=1 in RUN without hazard.
REQ-025 Stall counter 2 bits, loaded on RUN->STALL, decremented each STALL cycle, exits at 0.
REQ-026 Latency: one cycle from id capture to ALU operands; no hazard -> one instruction per cycle.
REQ-027 id_valid=0: no hazard raised, bubble captured, id_ready=1.

Reset
REQ-028 rst=1 at clk: FSM RUN, counter 0, ex_valid 0, all EX control bits 0, EX data/index registers 0, ALUControl 0.
REQ-029 Reset mid-stall aborts the stall; first cycle after reset id_ready=1.

Configuration
REQ-030 Macro ID_EX_FORWARD_EN defined: EX/MEM forwarding enabled; load-use hazard only (REQ-023); stall length 1 cycle.
REQ-031 Macro absent: no EX/MEM forwarding; hazard is any reg-writing EX slot with matching rd (any instruction, not only loads); stall length 2 cycles; WB bypass retained.

Structure
REQ-032 Shared package id_ex_pkg: ALU opcode constants (ADD 4'b0000 .. BEQ 4'b1101), FSM state enum, DATA_WIDTH/REG_ADDR_WIDTH defaults.
REQ-033 One sub-module fwd_unit: combinational match/priority select per source operand, instantiated twice.

Verification
REQ-034 add x5,x1,x2 then add x6,x5,x3 (ID_EX_FORWARD_EN, exm_result=0x10): SrcA=0x10, no stall.
REQ-035 lw x5 then add x6,x5,x5: id_ready=0 one cycle, ex_valid=0 bubble, then SrcA=SrcB=wb_result=0xAB.
REQ-036 exm and wb both write x7 (0x1 vs 0x2), consumer reads x7: SrcA=0x1; same with rd=x0: SrcA=id_rd1 registered value.
REQ-037 flush=1 with hazard pending: next cycle ex_valid=0, ex_reg_write=0, id_ready=1.
REQ-038 Macro absent, addi x5 then add x6,x5,x0: id_ready=0 two cycles, then SrcA=wb_result.
REQ-039 rst asserted mid-stall: next cycle ex_valid=0, ALUControl=0, id_ready=1.
